// File: rtl/aes_key_schedule.sv
// AES-128/192/256 word-serial key expansion; streams round keys 0..Nr over valid/ready.
// Optional round-key store enabled by defining KEY_STORE_EN.
module aes_key_schedule #(
    parameter int unsigned MAX_NK   = 8,
    parameter int unsigned RK_DEPTH = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   key_mode,
    input  logic [255:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         done,
    output logic         err,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned RK_W   = 128;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 6;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GEN, S_SUB, S_DRAIN} state_e;

    function automatic logic [7:0] sbox_f(input logic [7:0] b);
        return SBOX[~{b, 3'b000} -: 8];
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
    endfunction

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  win_q [MAX_NK];
    logic [WORD_W-1:0]  win_d [MAX_NK];
    logic [WORD_W-1:0]  asm_q [4];
    logic [WORD_W-1:0]  asm_d [4];
    logic               pend_q, pend_d;
    logic [WORD_W-1:0]  sub_q, sub_d;
    logic [CNT_W-1:0]   i_q, i_d, last_q, last_d;
    logic [2:0]         mod_q, mod_d;
    logic [7:0]         rcon_q, rcon_d;
    logic [IDX_W-1:0]   nk_q, nk_d;
    logic               busy_q, busy_d, rk_valid_q, rk_valid_d, done_q, done_d, err_q, err_d;
    logic [RK_W-1:0]    rk_data_q, rk_data_d;
    logic [IDX_W-1:0]   rk_idx_q, rk_idx_d;

    logic               slot_free, is_sub, wr;
    logic [IDX_W-1:0]   mode_nk;
    logic [WORD_W-1:0]  prev_w, new_w;

    // Next-state: FSM sequencing, window shift, round-key assembly and handshake.
    always_comb begin
        state_d = state_q;  pend_d = pend_q;  sub_d = sub_q;  i_d = i_q;  last_d = last_q;
        mod_d = mod_q;  rcon_d = rcon_q;  nk_d = nk_q;  busy_d = busy_q;
        rk_data_d = rk_data_q;  rk_idx_d = rk_idx_q;
        rk_valid_d = rk_valid_q & ~rk_ready;
        done_d = 1'b0;  err_d = 1'b0;  wr = 1'b0;
        for (int unsigned k = 0; k < MAX_NK; k++) win_d[k] = win_q[k];
        for (int unsigned k = 0; k < 4; k++) asm_d[k] = asm_q[k];

        slot_free = ~rk_valid_q | rk_ready;
        prev_w = '0;
        for (int unsigned k = 0; k < MAX_NK; k++)
            if (4'(k) == nk_q - 4'd1) prev_w = win_q[k];
        is_sub = (mod_q == 3'd0) || (nk_q == 4'd8 && mod_q == 3'd4);
        new_w  = win_q[0] ^ prev_w;
        case (key_mode)
            2'b00:   mode_nk = 4'd4;
            2'b01:   mode_nk = 4'd6;
            2'b10:   mode_nk = 4'd8;
            default: mode_nk = 4'd0;
        endcase

        case (state_q)
            S_IDLE: if (start) begin
                if (key_mode == 2'b11 || 32'(mode_nk) > MAX_NK) begin
                    err_d = 1'b1;
                end else begin
                    nk_d   = mode_nk;
                    last_d = CNT_W'(4 * 32'(mode_nk) + 27);
                    i_d    = CNT_W'(mode_nk);
                    mod_d  = 3'd0;
                    rcon_d = 8'h01;
                    pend_d = 1'b0;
                    busy_d = 1'b1;
                    for (int unsigned k = 0; k < MAX_NK; k++) win_d[k] = key[255 - 32*k -: 32];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                rk_data_d  = {win_q[0], win_q[1], win_q[2], win_q[3]};
                rk_idx_d   = '0;
                rk_valid_d = 1'b1;
                for (int unsigned k = 4; k < MAX_NK; k++)
                    if (4'(k) < nk_q) asm_d[2'(k - 4)] = win_q[k];
                pend_d  = (nk_q == 4'd8);
                state_d = S_GEN;
            end
            S_GEN: begin
                if (pend_q && slot_free) begin
                    rk_data_d  = {asm_q[0], asm_q[1], asm_q[2], asm_q[3]};
                    rk_idx_d   = 4'd1;
                    rk_valid_d = 1'b1;
                    pend_d     = 1'b0;
                end
                if (!pend_q || slot_free) begin
                    if (is_sub) begin
                        sub_d   = sub_word((mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w);
                        state_d = S_SUB;
                    end else begin
                        wr = 1'b1;
                    end
                end
            end
            S_SUB: begin
                new_w = win_q[0] ^ sub_q ^ ((mod_q == 3'd0) ? {rcon_q, 24'h0} : 32'h0);
                wr    = 1'b1;
            end
            S_DRAIN: if (rk_valid_q && rk_ready) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Commit a generated word unless it completes a group the consumer cannot take yet.
        if (wr && (i_q[1:0] != 2'd3 || slot_free)) begin
            for (int unsigned k = 0; k + 1 < MAX_NK; k++)
                if (4'(k) < nk_q - 4'd1) win_d[k] = win_q[k + 1];
            for (int unsigned k = 0; k < MAX_NK; k++)
                if (4'(k) == nk_q - 4'd1) win_d[k] = new_w;
            asm_d[i_q[1:0]] = new_w;
            if (i_q[1:0] == 2'd3) begin
                rk_data_d  = {asm_q[0], asm_q[1], asm_q[2], new_w};
                rk_idx_d   = i_q[5:2];
                rk_valid_d = 1'b1;
            end
            if (mod_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            mod_d   = ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
            i_d     = i_q + CNT_W'(1);
            state_d = (i_q == last_q) ? S_DRAIN : S_GEN;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;  pend_q <= 1'b0;  sub_q <= '0;  i_q <= '0;  last_q <= '0;
            mod_q <= '0;  rcon_q <= '0;  nk_q <= '0;  busy_q <= 1'b0;  rk_valid_q <= 1'b0;
            done_q <= 1'b0;  err_q <= 1'b0;  rk_data_q <= '0;  rk_idx_q <= '0;
            for (int unsigned k = 0; k < MAX_NK; k++) win_q[k] <= '0;
            for (int unsigned k = 0; k < 4; k++) asm_q[k] <= '0;
        end else begin
            state_q <= state_d;  pend_q <= pend_d;  sub_q <= sub_d;  i_q <= i_d;  last_q <= last_d;
            mod_q <= mod_d;  rcon_q <= rcon_d;  nk_q <= nk_d;  busy_q <= busy_d;  rk_valid_q <= rk_valid_d;
            done_q <= done_d;  err_q <= err_d;  rk_data_q <= rk_data_d;  rk_idx_q <= rk_idx_d;
            for (int unsigned k = 0; k < MAX_NK; k++) win_q[k] <= win_d[k];
            for (int unsigned k = 0; k < 4; k++) asm_q[k] <= asm_d[k];
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;
    assign done     = done_q;
    assign err      = err_q;

`ifdef KEY_STORE_EN
    logic [RK_W-1:0] store_q [RK_DEPTH];

    // Capture every accepted round key by its round index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < RK_DEPTH; k++) store_q[k] <= '0;
        end else if (rk_valid_q && rk_ready) begin
            for (int unsigned k = 0; k < RK_DEPTH; k++)
                if (4'(k) == rk_idx_q) store_q[k] <= rk_data_q;
        end
    end

    // Combinational read; indices past the store depth read as zero.
    always_comb begin
        rd_key = '0;
        for (int unsigned k = 0; k < RK_DEPTH; k++)
            if (4'(k) == rd_idx) rd_key = store_q[k];
    end
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^{rd_idx, RK_DEPTH[0]};
    assign rd_key = '0;
`endif

endmodule
